// File: rtl/mio_pkg.sv
// Shared types and address map for the CPU memory/IO bus responder.
package mio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RDLAT,
        ST_DONE
    } state_e;

    localparam logic [12:0] IO_LED = 13'h1000;
    localparam logic [12:0] IO_SW  = 13'h1004;
    localparam logic [12:0] IO_CNT = 13'h1008;

    localparam int RAM_AW = 10;

endpackage

// File: rtl/mio_io_regs.sv
// LED register, switch read mux and free-running cycle counter; reads are combinational,
// writes take effect on the strobe edge; no backpressure (strobe is always accepted).
module mio_io_regs
    import mio_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [10:0] waddr,
    input  logic [7:0]  wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  sw_in,
    output logic [7:0]  led_out
);

    logic [7:0]       led_q, led_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        led_d = led_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (wr_en && waddr == IO_LED[12:2]) led_d = wdata;
        // A clearing write wins over this cycle's increment.
        if (wr_en && waddr == IO_CNT[12:2]) cnt_d = '0;

        rdata = '0;
        if (waddr == IO_LED[12:2]) rdata = {24'h0, led_q};
        if (waddr == IO_SW[12:2])  rdata = {24'h0, sw_in};
        if (waddr == IO_CNT[12:2]) rdata = 32'(cnt_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q <= '0;
            cnt_q <= '0;
        end else begin
            led_q <= led_d;
            cnt_q <= cnt_d;
        end
    end

    assign led_out = led_q;

endmodule

// File: rtl/mio_bus_responder.sv
// Bus responder: RAM/IO decode with wait states; ready after WAIT_CYCLES+2 (+RAM_LAT for RAM reads).
// Holds mio_ready until the CPU drops its request; no new access is taken before that.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int RAM_LAT     = 1,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic [12:0]       addr_in,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              mio_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [7:0]        sw_in,
    output logic [7:0]        led_out
);

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [1:0]  lcnt_q, lcnt_d;
    logic        op_wr_q, op_wr_d;
    logic [10:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_out_q, data_out_d;
    logic        mio_ready_q, mio_ready_d;
    logic        ram_en_q, ram_en_d;
    logic        ram_we_q, ram_we_d;
    logic        io_we;
    logic [31:0] io_rdata;
    logic        addr_unused;

    assign addr_unused = ^addr_in[1:0];

    mio_io_regs #(.CNT_W(CNT_W)) u_io_regs (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (io_we),
        .waddr   (addr_q),
        .wdata   (wdata_q[7:0]),
        .rdata   (io_rdata),
        .sw_in   (sw_in),
        .led_out (led_out)
    );

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        lcnt_d     = lcnt_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        io_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_r || mem_w) begin
                    op_wr_d = mem_w;
                    addr_d  = addr_in[12:2];
                    if (mem_w) wdata_d = data_in;
                    wcnt_d  = '0;
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 4'(WAIT_CYCLES - 1)) state_d = ST_ACCESS;
                else                               wcnt_d  = wcnt_q + 4'd1;
            end
            ST_ACCESS: begin
                if (op_wr_q) begin
                    io_we   = addr_q[10];
                    state_d = ST_DONE;
                end else if (addr_q[10]) begin
                    data_out_d = io_rdata;
                    state_d    = ST_DONE;
                end else begin
                    lcnt_d  = '0;
                    state_d = ST_RDLAT;
                end
            end
            ST_RDLAT: begin
                // The enable cycle already counted as the first latency cycle.
                if (lcnt_q == 2'(RAM_LAT - 1)) begin
                    data_out_d = ram_dout;
                    state_d    = ST_DONE;
                end else begin
                    lcnt_d = lcnt_q + 2'd1;
                end
            end
            ST_DONE: begin
                if (!mem_r && !mem_w) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ram_en_d    = (state_d == ST_ACCESS) && !addr_d[10];
        ram_we_d    = ram_en_d && op_wr_d;
        mio_ready_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            lcnt_q      <= '0;
            op_wr_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_out_q  <= '0;
            mio_ready_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            lcnt_q      <= lcnt_d;
            op_wr_q     <= op_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            data_out_q  <= data_out_d;
            mio_ready_q <= mio_ready_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
        end
    end

    assign data_out  = data_out_q;
    assign mio_ready = mio_ready_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = addr_q[RAM_AW-1:0];
    assign ram_din   = wdata_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Two responders (no-wait/1-cycle RAM and 3-wait/2-cycle RAM with a 4-bit counter)
// driven with directed and random bus transactions against a memory/register model.
module tb_mio_bus_responder;
    import mio_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n   [2];
    logic        mem_r     [2];
    logic        mem_w     [2];
    logic [12:0] addr_in   [2];
    logic [31:0] data_in   [2];
    logic [31:0] data_out  [2];
    logic        mio_ready [2];
    logic        ram_en    [2];
    logic        ram_we    [2];
    logic [9:0]  ram_addr  [2];
    logic [31:0] ram_din   [2];
    logic [31:0] ram_dout  [2];
    logic [7:0]  sw_in     [2];
    logic [7:0]  led_out   [2];

    mio_bus_responder #(.WAIT_CYCLES(0), .RAM_LAT(1), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset_n[0]), .mem_r(mem_r[0]), .mem_w(mem_w[0]),
        .addr_in(addr_in[0]), .data_in(data_in[0]), .data_out(data_out[0]),
        .mio_ready(mio_ready[0]), .ram_en(ram_en[0]), .ram_we(ram_we[0]),
        .ram_addr(ram_addr[0]), .ram_din(ram_din[0]), .ram_dout(ram_dout[0]),
        .sw_in(sw_in[0]), .led_out(led_out[0])
    );

    mio_bus_responder #(.WAIT_CYCLES(3), .RAM_LAT(2), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset_n[1]), .mem_r(mem_r[1]), .mem_w(mem_w[1]),
        .addr_in(addr_in[1]), .data_in(data_in[1]), .data_out(data_out[1]),
        .mio_ready(mio_ready[1]), .ram_en(ram_en[1]), .ram_we(ram_we[1]),
        .ram_addr(ram_addr[1]), .ram_din(ram_din[1]), .ram_dout(ram_dout[1]),
        .sw_in(sw_in[1]), .led_out(led_out[1])
    );

    function automatic int wc(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic int lt(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic logic [31:0] init_word(input int i, input int j);
        return 32'(j * 32'h9E37_79B1) ^ ((i == 0) ? 32'h0000_A5A5 : 32'h5A5A_0000);
    endfunction

    // Synchronous RAM devices with per-instance read latency, plus strobe monitors.
    logic [31:0] ram_mem [2][1024];
    logic [31:0] rd_pipe [2][2];
    bit          ram_init;
    int          we_cnt  [2];
    int          en_cnt  [2];
    logic [9:0]  we_addr [2];
    logic [31:0] we_dat  [2];
    int unsigned cyc;

    assign ram_dout[0] = rd_pipe[0][0];
    assign ram_dout[1] = rd_pipe[1][1];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            rd_pipe[i][1] <= rd_pipe[i][0];
            rd_pipe[i][0] <= 32'hDEAD_BEEF;
            if (!ram_init)
                for (int j = 0; j < 1024; j++) ram_mem[i][j] <= init_word(i, j);
            if (ram_we[i]) begin
                we_cnt[i]++;
                we_addr[i] = ram_addr[i];
                we_dat[i]  = ram_din[i];
            end
            if (ram_en[i]) begin
                en_cnt[i]++;
                if (ram_we[i]) ram_mem[i][ram_addr[i]] <= ram_din[i];
                else           rd_pipe[i][0] <= ram_mem[i][ram_addr[i]];
            end
        end
        ram_init <= 1'b1;
    end

    // Reference model of the architectural state visible over the bus.
    logic [31:0] ref_ram [2][1024];
    logic [7:0]  ref_led [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int i, input logic [12:0] a);
        logic [12:0] w;
        w = {a[12:2], 2'b00};
        if (!a[12])      return ref_ram[i][a[11:2]];
        if (w == IO_LED) return {24'h0, ref_led[i]};
        if (w == IO_SW)  return {24'h0, sw_in[i]};
        return 32'h0;
    endfunction

    task automatic chk_zero_outputs(input int i);
        chk("rst_data_out", data_out[i], 32'h0);
        chk("rst_ready", 32'(mio_ready[i]), 32'h0);
        chk("rst_ram_en", 32'(ram_en[i]), 32'h0);
        chk("rst_ram_we", 32'(ram_we[i]), 32'h0);
        chk("rst_led", 32'(led_out[i]), 32'h0);
        chk("rst_ram_addr", 32'(ram_addr[i]), 32'h0);
        chk("rst_ram_din", ram_din[i], 32'h0);
    endtask

    // One full handshake. pulse drops the request right after it is sampled.
    task automatic txn(input int i, input bit wr, input bit both, input logic [12:0] a,
                       input logic [31:0] d, input int hold, input bit pulse,
                       output logic [31:0] rd, output int unsigned t_rdy);
        int  we0, en0, k, exp_lat;
        bit  is_ram;
        is_ram  = !a[12];
        we0     = we_cnt[i];
        en0     = en_cnt[i];
        exp_lat = wc(i) + 2 + ((!wr && is_ram) ? lt(i) : 0);
        @(negedge clk);
        addr_in[i] = a;
        data_in[i] = d;
        mem_w[i]   = wr;
        mem_r[i]   = !wr || both;
        k = 0;
        while (k < 64) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                addr_in[i] = 13'($urandom);
                data_in[i] = $urandom;
                if (pulse) begin
                    mem_r[i] = 1'b0;
                    mem_w[i] = 1'b0;
                end
            end
            if (mio_ready[i]) break;
        end
        chk("latency", 32'(k), 32'(exp_lat));
        rd    = data_out[i];
        t_rdy = cyc;
        if (!pulse) begin
            repeat (hold) begin
                @(posedge clk); #1;
                chk("ready_hold", 32'(mio_ready[i]), 32'h1);
            end
            @(negedge clk);
            mem_r[i] = 1'b0;
            mem_w[i] = 1'b0;
        end
        @(posedge clk); #1;
        chk("ready_drop", 32'(mio_ready[i]), 32'h0);
        chk("dout_hold", data_out[i], rd);
        chk("we_count", 32'(we_cnt[i] - we0), 32'(wr && is_ram));
        chk("en_count", 32'(en_cnt[i] - en0), 32'(is_ram));
        if (wr && is_ram) begin
            chk("we_addr", 32'(we_addr[i]), 32'(a[11:2]));
            chk("we_data", we_dat[i], d);
            ref_ram[i][a[11:2]] = d;
        end
        if (wr && {a[12:2], 2'b00} == IO_LED) ref_led[i] = d[7:0];
        chk("led_out", 32'(led_out[i]), 32'(ref_led[i]));
    endtask

    initial begin
        logic [31:0] rd, v1, v2, v3, d, e;
        int unsigned t1, t2, t3, tw;
        logic [12:0] a;
        int sel, we0;
        bit wr, both, pulse;

        for (int i = 0; i < 2; i++) begin
            reset_n[i] = 1'b0;
            mem_r[i]   = 1'b0;
            mem_w[i]   = 1'b0;
            addr_in[i] = '0;
            data_in[i] = '0;
            sw_in[i]   = 8'h00;
            ref_led[i] = 8'h00;
            for (int j = 0; j < 1024; j++) ref_ram[i][j] = init_word(i, j);
        end
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs(0);
        chk_zero_outputs(1);
        @(negedge clk);
        reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;

        // No wait states, single-cycle RAM.
        txn(0, 1, 0, 13'h0010, 32'h1234_5678, 0, 0, rd, t1);
        txn(0, 0, 0, 13'h0010, 32'h0, 0, 0, rd, t1);
        chk("ram_readback", rd, 32'h1234_5678);
        txn(0, 1, 0, 13'h1000, 32'h0000_00A5, 0, 0, rd, t1);
        chk("led_a5", 32'(led_out[0]), 32'hA5);
        sw_in[0] = 8'h3C;
        txn(0, 0, 0, 13'h1004, 32'h0, 0, 0, rd, t1);
        chk("sw_read", rd, 32'h0000_003C);
        txn(0, 0, 0, 13'h1020, 32'h0, 0, 0, rd, t1);
        chk("unmapped_read", rd, 32'h0);
        txn(0, 0, 0, 13'h0010, 32'h0, 6, 0, rd, t1);
        chk("held_read", rd, 32'h1234_5678);

        txn(0, 0, 0, IO_CNT, 32'h0, 0, 0, v1, t1);
        repeat (7) @(posedge clk);
        txn(0, 0, 0, IO_CNT, 32'h0, 0, 0, v2, t2);
        chk("cnt_delta", v2 - v1, 32'(t2 - t1));
        txn(0, 1, 0, IO_CNT, 32'hFFFF_FFFF, 0, 0, rd, tw);
        txn(0, 0, 0, IO_CNT, 32'h0, 0, 0, v3, t3);
        chk("cnt_after_clear", v3, 32'(t3 - tw - 1));
        chk("cnt_cleared_lower", 32'(v3 < v2), 32'h1);

        // Three wait states, two-cycle RAM, 4-bit counter.
        txn(1, 1, 0, 13'h0040, 32'hA1B2_C3D4, 0, 0, rd, t1);
        txn(1, 0, 0, 13'h0040, 32'h0, 0, 0, rd, t1);
        chk("b_ram_readback", rd, 32'hA1B2_C3D4);
        txn(1, 1, 0, 13'h0080, 32'h0BAD_CAFE, 0, 1, rd, t1);
        txn(1, 0, 0, 13'h0080, 32'h0, 0, 1, rd, t1);
        chk("b_early_drop_rd", rd, 32'h0BAD_CAFE);
        txn(1, 0, 0, IO_CNT, 32'h0, 0, 0, v1, t1);
        repeat (19) @(posedge clk);
        txn(1, 0, 0, IO_CNT, 32'h0, 0, 0, v2, t2);
        chk("b_cnt_wrap", v2, 32'((v1 + (t2 - t1)) % 16));
        txn(1, 1, 0, 13'h1000, 32'h0000_005A, 0, 0, rd, t1);

        // Reset in the middle of a write's wait phase.
        we0 = we_cnt[1];
        @(negedge clk);
        addr_in[1] = 13'h0100;
        data_in[1] = 32'hCAFE_F00D;
        mem_w[1]   = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        reset_n[1] = 1'b0;
        #1;
        chk_zero_outputs(1);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_write", 32'(we_cnt[1] - we0), 32'h0);
        mem_w[1] = 1'b0;
        @(negedge clk);
        reset_n[1] = 1'b1;
        ref_led[1] = 8'h00;
        txn(1, 0, 0, 13'h0100, 32'h0, 0, 0, rd, t1);
        chk("rst_ram_untouched", rd, ref_ram[1][64]);

        // Random mix of reads/writes over RAM, LED, switches and unmapped IO.
        for (int i = 0; i < 2; i++) begin
            repeat (40) begin
                sel   = $urandom_range(0, 4);
                wr    = 1'($urandom_range(0, 1));
                both  = wr && ($urandom_range(0, 1) == 1);
                pulse = ($urandom_range(0, 7) == 0);
                d     = $urandom;
                sw_in[i] = 8'($urandom);
                case (sel)
                    0, 1:    a = {1'b0, 10'($urandom_range(0, 31)), 2'($urandom)};
                    2:       a = IO_LED | 13'($urandom_range(0, 3));
                    3:       a = IO_SW | 13'($urandom_range(0, 3));
                    default: a = IO_LED + 13'(4 * $urandom_range(3, 1023)) + 13'($urandom_range(0, 3));
                endcase
                e = exp_rd(i, a);
                txn(i, wr, both, a, d, $urandom_range(0, 3), pulse, rd, t1);
                if (!wr) chk("rand_read", rd, e);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
